// File: rtl/c2sif_arb.sv
// Round-robin arbiter funnelling NREQ four-phase upstream requesters onto a single
// four-phase downstream driver bus, with a downstream ack timeout.
module c2sif_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DW   = 32,
    parameter int unsigned IDW  = 8,
    parameter int unsigned FNW  = 4,
    parameter int unsigned TMO  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]     m_req,
    input  logic [NREQ*IDW-1:0] m_id,
    input  logic [NREQ*FNW-1:0] m_fn,
    input  logic [NREQ*DW-1:0]  m_data,
    output logic [NREQ-1:0]     m_ack,
    output logic [NREQ-1:0]     m_err,
    output logic [DW-1:0]       m_rdata,
    output logic                s_req,
    output logic [IDW-1:0]      s_id,
    output logic [FNW-1:0]      s_fn,
    output logic [DW-1:0]       s_data,
    input  logic                s_ack,
    input  logic [DW-1:0]       s_rdata,
    output logic [NREQ-1:0]     grant,
    output logic                busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(TMO);
    localparam logic [CW-1:0] CntLast = CW'(TMO - 1);

    typedef enum logic [1:0] {StIdle, StDreq, StDrel, StUack} state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [IDW-1:0]    sid_q, sid_d;
    logic [FNW-1:0]    sfn_q, sfn_d;
    logic [DW-1:0]     sdata_q, sdata_d;

    logic              win_found;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     cand;

    // First requester at or after ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = PW'((32'(ptr_q) + k) % NREQ);
            if (!win_found && m_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        sid_d   = sid_q;
        sfn_d   = sfn_q;
        sdata_d = sdata_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d = NREQ'(1) << win_idx;
                    gidx_d  = win_idx;
                    sid_d   = m_id[win_idx*IDW +: IDW];
                    sfn_d   = m_fn[win_idx*FNW +: FNW];
                    sdata_d = m_data[win_idx*DW +: DW];
                    cnt_d   = '0;
                    state_d = StDreq;
                end
            end
            StDreq: begin
                cnt_d = cnt_q + CW'(1);
                // Ack wins over a simultaneous timeout.
                if (s_ack) begin
                    rdata_d = s_rdata;
                    err_d   = 1'b0;
                    state_d = StDrel;
                end else if (cnt_q == CntLast) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDrel;
                end
            end
            StDrel: begin
                if (!s_ack) begin
                    state_d = StUack;
                end
            end
            StUack: begin
                if (!m_req[gidx_q]) begin
                    ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
                    grant_d = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            sid_q   <= '0;
            sfn_q   <= '0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            sid_q   <= sid_d;
            sfn_q   <= sfn_d;
            sdata_q <= sdata_d;
        end
    end

    assign s_req   = (state_q == StDreq);
    assign busy    = (state_q != StIdle);
    assign grant   = grant_q;
    assign m_ack   = (state_q == StUack) ? grant_q : '0;
    assign m_err   = m_ack & {NREQ{err_q}};
    assign m_rdata = rdata_q;
    assign s_id    = sid_q;
    assign s_fn    = sfn_q;
    assign s_data  = sdata_q;

endmodule

// File: tb/tb_c2sif_arb.sv
// Directed bench for c2sif_arb: single request, timeout, ack/timeout tie, early drop,
// asynchronous reset mid-transaction and four-way round-robin contention.
module tb_c2sif_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned IDW  = 8;
    localparam int unsigned FNW  = 4;
    localparam int unsigned TMO  = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      m_req;
    logic [NREQ*IDW-1:0]  m_id;
    logic [NREQ*FNW-1:0]  m_fn;
    logic [NREQ*DW-1:0]   m_data;
    logic [NREQ-1:0]      m_ack;
    logic [NREQ-1:0]      m_err;
    logic [DW-1:0]        m_rdata;
    logic                 s_req;
    logic [IDW-1:0]       s_id;
    logic [FNW-1:0]       s_fn;
    logic [DW-1:0]        s_data;
    logic                 s_ack;
    logic [DW-1:0]        s_rdata;
    logic [NREQ-1:0]      grant;
    logic                 busy;

    int n_checks = 0;
    int n_errors = 0;

    c2sif_arb #(
        .NREQ(NREQ),
        .DW  (DW),
        .IDW (IDW),
        .FNW (FNW),
        .TMO (TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_id   (m_id),
        .m_fn   (m_fn),
        .m_data (m_data),
        .m_ack  (m_ack),
        .m_err  (m_err),
        .m_rdata(m_rdata),
        .s_req  (s_req),
        .s_id   (s_id),
        .s_fn   (s_fn),
        .s_data (s_data),
        .s_ack  (s_ack),
        .s_rdata(s_rdata),
        .grant  (grant),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sreq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  hi_cnt;
        bit  ok;

        rst     = 1'b0;
        m_req   = '0;
        m_id    = {8'h44, 8'h05, 8'h22, 8'h11};
        m_fn    = {4'h3, 4'h0, 4'h2, 4'h1};
        m_data  = {32'h4444, 32'h1, 32'h2222, 32'h1111};
        s_ack   = 1'b0;
        s_rdata = '0;

        // Reset state, with requests present that must be ignored
        @(negedge clk);
        m_req = 4'hF;
        @(negedge clk);
        check("rst_sreq",  s_req,   0);
        check("rst_mack",  m_ack,   0);
        check("rst_merr",  m_err,   0);
        check("rst_grant", grant,   0);
        check("rst_busy",  busy,    0);
        check("rst_rdata", m_rdata, 0);
        check("rst_sid",   s_id,    0);
        check("rst_sfn",   s_fn,    0);
        check("rst_sdata", s_data,  0);
        m_req = '0;
        rst   = 1'b1;

        // Single request from slot 2
        @(negedge clk);
        m_req = 4'b0100;
        @(negedge clk);
        check("t1_sreq",  s_req,  1);
        check("t1_sid",   s_id,   8'h05);
        check("t1_sfn",   s_fn,   0);
        check("t1_sdata", s_data, 32'h1);
        check("t1_grant", grant,  4'b0100);
        check("t1_busy",  busy,   1);
        m_req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t1_grant_hold", grant, 4'b0100);
        s_ack   = 1'b1;
        s_rdata = 32'hA5;
        @(negedge clk);
        check("t1_drel_sreq",  s_req, 0);
        check("t1_drel_grant", grant, 4'b0100);
        s_ack   = 1'b0;
        s_rdata = '0;
        @(negedge clk);
        check("t1_mack",  m_ack,   4'b0100);
        check("t1_merr",  m_err,   0);
        check("t1_rdata", m_rdata, 32'hA5);
        check("t1_sid_hold", s_id, 8'h05);
        m_req = '0;
        @(negedge clk);
        check("t1_done_mack",  m_ack, 0);
        check("t1_done_grant", grant, 0);
        check("t1_done_busy",  busy,  0);

        // Timeout on slot 1 (ptr now 3, slot 1 is the only requester)
        m_req  = 4'b0010;
        hi_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!s_req) break;
            hi_cnt++;
        end
        check("to_sreq_cycles", hi_cnt, TMO);
        @(negedge clk);
        check("to_mack",  m_ack,   4'b0010);
        check("to_merr",  m_err,   4'b0010);
        check("to_rdata", m_rdata, 0);
        m_req = '0;
        @(negedge clk);
        check("to_done_busy", busy, 0);

        // Ack arrives in the same cycle the counter reaches TMO-1 (slot 0)
        m_req = 4'b0001;
        repeat (TMO) @(negedge clk);
        check("tie_sreq_before", s_req, 1);
        s_ack   = 1'b1;
        s_rdata = 32'h5A5A_0001;
        @(negedge clk);
        check("tie_sreq_after", s_req, 0);
        s_ack   = 1'b0;
        s_rdata = '0;
        @(negedge clk);
        check("tie_mack",  m_ack,   4'b0001);
        check("tie_merr",  m_err,   0);
        check("tie_rdata", m_rdata, 32'h5A5A_0001);
        m_req = '0;
        @(negedge clk);

        // Granted requester drops m_req during DREQ (slot 1)
        m_req = 4'b0010;
        @(negedge clk);
        check("ed_sreq",  s_req, 1);
        check("ed_grant", grant, 4'b0010);
        m_req = '0;
        @(negedge clk);
        check("ed_sreq_kept", s_req, 1);
        s_ack   = 1'b1;
        s_rdata = 32'h77;
        @(negedge clk);
        check("ed_drel_sreq", s_req, 0);
        s_ack   = 1'b0;
        s_rdata = '0;
        @(negedge clk);
        check("ed_mack",  m_ack,   4'b0010);
        check("ed_rdata", m_rdata, 32'h77);
        @(negedge clk);
        check("ed_mack_pulse", m_ack, 0);
        check("ed_idle",       busy,  0);

        // Asynchronous reset while s_req=1 (ptr now 2)
        m_req = 4'b1000;
        @(negedge clk);
        check("rm_sreq",  s_req, 1);
        check("rm_grant", grant, 4'b1000);
        #2 rst = 1'b0;
        #1;
        check("rm_async_sreq",  s_req, 0);
        check("rm_async_grant", grant, 0);
        check("rm_async_busy",  busy,  0);
        @(negedge clk);
        rst   = 1'b1;
        m_req = 4'b1001;
        @(negedge clk);
        check("rm_slot0_first", grant, 4'b0001);

        // Contention: all four held from reset, each drops after its ack
        rst   = 1'b0;
        m_req = 4'hF;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_sreq(ok);
            check("ct_sreq_seen", ok, 1);
            check("ct_grant", grant, 64'(1) << k);
            s_ack = 1'b1;
            @(negedge clk);
            s_ack = 1'b0;
            @(negedge clk);
            check("ct_mack", m_ack, 64'(1) << k);
            m_req[k] = 1'b0;
            @(negedge clk);
        end
        check("ct_idle", busy, 0);
        // ptr back at 0: slot 0 beats slot 3
        m_req = 4'b1001;
        @(negedge clk);
        check("ct_ptr_wrap", grant, 4'b0001);
        m_req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/c2sif_arb.md
C2SIF_ARB -- requirements
Module: c2sif_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of upstream requesters; DW, default 32, data width; IDW, default 8, id width; FNW, default 4, function-code width; TMO, default 1024, downstream ack timeout in cycles (TMO >= 2).
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- m_req  in  NREQ  per-requester 4-phase request.
- m_id  in  NREQ*IDW  per-requester target id; slot i at [i*IDW +: IDW].
- m_fn  in  NREQ*FNW  per-requester function code.
- m_data  in  NREQ*DW  per-requester write data.
- m_ack  out  NREQ  per-requester acknowledge.
- m_err  out  NREQ  per-requester timeout flag, valid while m_ack[i]=1.
- m_rdata  out  DW  read data of the completed transaction, shared.
- s_req  out  1  downstream request to the driver bus.
- s_id  out  IDW  latched id.
- s_fn  out  FNW  latched function code.
- s_data  out  DW  latched write data.
- s_ack  in  1  downstream acknowledge.
- s_rdata  in  DW  downstream read data, valid while s_ack=1.
- grant  out  NREQ  one-hot owner of the bus; all zero in IDLE.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 FSM states SHALL be IDLE, DREQ, DREL, UACK.
REQ-004 In IDLE, arbitration SHALL be round-robin: the first i with m_req[i]=1, searching from pointer ptr upward and wrapping modulo NREQ.
REQ-005 On the edge where IDLE sees any m_req set, the block SHALL do all of the following:
- latch winner g into grant;
- latch m_id, m_fn and m_data slot g into s_id, s_fn and s_data;
- clear the timeout counter;
- enter DREQ.
Result: s_req=1 one cycle after m_req[g] is sampled high.
REQ-006 In DREQ, s_req SHALL be 1 and the counter SHALL increment each cycle.
REQ-007 When s_ack=1 is sampled in DREQ:
- s_rdata SHALL be captured into m_rdata;
- the error bit SHALL be cleared;
- the FSM SHALL enter DREL.
REQ-008 If the counter reaches TMO-1 in DREQ with s_ack=0:
- the error bit SHALL be set;
- m_rdata SHALL be zeroed;
- the FSM SHALL enter DREL.
REQ-009 s_ack=1 and timeout in the same cycle SHALL resolve as ack (no error).
REQ-010 In DREL, s_req SHALL be 0; the FSM SHALL stay until s_ack=0 is sampled, then enter UACK.
REQ-011 In UACK:
- m_ack[g] SHALL be 1 and m_err[g] SHALL equal the error bit;
- when m_req[g]=0 is sampled, the block SHALL deassert m_ack[g], set ptr to (g+1) mod NREQ, clear grant, and enter IDLE.
REQ-012 m_ack and m_err bits for non-granted requesters SHALL be 0 at all times.
REQ-013 s_id, s_fn and s_data SHALL be held stable from DREQ entry until IDLE re-entry.
REQ-014 m_rdata SHALL hold its value until the next capture.
REQ-015 Requests arriving or dropping for non-granted slots during a transaction SHALL be ignored until IDLE.
REQ-016 A granted requester dropping m_req before ack SHALL NOT abort the downstream transaction. UACK then lasts exactly one cycle (m_ack[g] pulses).
REQ-017 Back-to-back transactions SHALL have at least one IDLE cycle between UACK exit and the next DREQ.

Reset
REQ-018 While rst=0, the block SHALL be in IDLE with all of the following zero: s_req, m_ack, m_err, grant, busy, m_rdata, s_id, s_fn, s_data, counter, ptr.
REQ-019 Reset asserted mid-transaction SHALL abandon it immediately (s_req and m_ack drop asynchronously). Operation SHALL restart from ptr=0 on the first clock after rst=1.

Verification
REQ-020 Single request:
- stimulus: m_req[2]=1, id=0x05, fn=0, data=0x1; driver acks after 3 cycles with s_rdata=0xA5;
- response: s_req rises 1 cycle after m_req; s_id=0x05; m_ack[2]=1, m_err[2]=0, m_rdata=0xA5; grant=0b0100 throughout.
REQ-021 Contention:
- stimulus: all four m_req held high from reset, each dropping after its ack;
- response: grant order 0,1,2,3; ptr then equals 0.
REQ-022 Timeout:
- stimulus: TMO=16, s_ack never rises;
- response: s_req high exactly 16 cycles, then m_ack[g]=1, m_err[g]=1, m_rdata=0.
REQ-023 Ack/timeout tie:
- stimulus: s_ack rises in the same cycle the counter reaches TMO-1;
- response: m_err[g]=0 and data captured.
REQ-024 Early drop:
- stimulus: m_req[1] drops while in DREQ;
- response: downstream completes; m_ack[1] is a 1-cycle pulse; then IDLE.
REQ-025 Reset mid-DREQ:
- stimulus: rst=0 while s_req=1;
- response: s_req=0 and grant=0 without waiting for a clock; the next request from slot 0 wins first.
